board_clock_enable_gen: RTL
===========================

Name: board_clock_enable_gen

Overview:
- Consumes the 107.4 MHz base clock produced by the board clock PLL and divides it back down into phase-aligned single-cycle clock enables: 21.48 MHz, 10.74 MHz, the 3.58 MHz CPU rise/fall enables, and a 1 kHz tick.
- Sequences the system reset and the video reset: outputs stay in reset until the PLL lock indications have held stable for a programmable time.
- Provides a pause handshake that freezes the enables on a CPU-cycle boundary.

Parameters:
- BASE_DIV, 30: base cycles per 3.58 MHz period. Must be a multiple of 10.
- TICK_DIV, 107400: base cycles per TICK_1K pulse.
- RST_HOLD, 16: EN_3M58 periods that each reset output is held after its qualifying input goes high.
- SYNC_STAGES, 2: synchronizer depth for TMDS_READY.

Ports:
- CLK, input, 1: 107.4 MHz base clock. This is the only clock in the block.
- RESET_n, input, 1: synchronous, active-low reset. The board drives it from the base clock READY signal.
- TMDS_READY, input, 1: TMDS PLL ready. It is a level from another clock domain and is treated as asynchronous.
- PAUSE_REQ, input, 1: request to freeze all enables.
- PAUSE_ACK, output, 1: high while the block is frozen.
- EN_21M, output, 1: 1-cycle pulse every 5 base cycles.
- EN_10M, output, 1: 1-cycle pulse every 10 base cycles.
- EN_3M58_R, output, 1: CPU clock rising-edge enable, once per BASE_DIV cycles.
- EN_3M58_F, output, 1: CPU clock falling-edge enable, offset BASE_DIV/2 cycles from EN_3M58_R.
- CLK_3M58, output, 1: registered 50 % duty level of the CPU clock.
- TICK_1K, output, 1: 1-cycle pulse every TICK_DIV cycles.
- SYS_RESET_n, output, 1: sequenced system reset.
- VID_RESET_n, output, 1: sequenced video reset.

Behaviour:
- Reset: while RESET_n=0, every output is 0. This covers all EN_*, CLK_3M58, TICK_1K, PAUSE_ACK, SYS_RESET_n and VID_RESET_n. All counters and synchronizer flops are cleared to 0.
- Prescaler: pcnt counts 0..BASE_DIV-1 and wraps to 0. It advances only when it is not frozen.
- Enable decode is registered, so each pulse appears one cycle after the pcnt value that decodes it. With the default BASE_DIV=30:
  - EN_21M for pcnt in {4,9,14,19,24,29}.
  - EN_10M for pcnt in {9,19,29}.
  - EN_3M58_R for pcnt==29.
  - EN_3M58_F for pcnt==14.
- Alignment: each EN_3M58_R coincides with an EN_10M pulse and an EN_21M pulse.
- First pulse: after RESET_n rises, the first EN_21M occurs 5 cycles later. The first EN_3M58_R occurs 30 cycles later.
- CLK_3M58: set to 1 on the cycle EN_3M58_R is asserted and cleared on the cycle EN_3M58_F is asserted.
- TICK_1K: a 17-bit counter over 0..TICK_DIV-1. It pulses on wrap. It is not frozen by pause.
- Pause FSM, states RUN, DRAIN, PAUSED:
  - RUN→DRAIN when PAUSE_REQ=1.
  - DRAIN→PAUSED on the cycle EN_3M58_R is asserted. That pulse is still emitted.
  - In PAUSED: pcnt holds at 0, all EN_* stay 0, CLK_3M58 holds 1, and PAUSE_ACK=1.
  - PAUSED→RUN when PAUSE_REQ=0. PAUSE_ACK drops in the same cycle as the transition and pcnt resumes from 0.
  - DRAIN→RUN if PAUSE_REQ drops before the boundary. PAUSE_ACK never asserts in that case.
- TMDS_READY synchronizer: SYNC_STAGES flops, giving tmds_ok.
- SYS_RESET_n sequencing:
  - A hold counter, sys_hold, counts EN_3M58_R pulses, and only outside PAUSED.
  - SYS_RESET_n goes to 1 on the cycle after sys_hold reaches RST_HOLD. It then stays 1 until RESET_n falls.
- VID_RESET_n sequencing:
  - A counter, vid_hold, counts EN_3M58_R pulses only while tmds_ok=1 and SYS_RESET_n=1.
  - VID_RESET_n goes to 1 when vid_hold reaches RST_HOLD.
  - If tmds_ok falls at any time, VID_RESET_n goes to 0 on the next cycle and vid_hold clears. The hold restarts when tmds_ok returns.
- Counter saturation: hold counters saturate at RST_HOLD and never wrap.
- RESET_n falling mid-operation: all state clears on the next edge, including while in PAUSED or DRAIN.

Decomposition:
- Shared package board_clock_pkg:
  - Pause FSM state enum (RUN, DRAIN, PAUSED).
  - Constants for BASE_FREQ_KHZ = 107400, the 21M divisor 5, and the 10M divisor 10.
  - Pulse-offset localparams derived from BASE_DIV.
- One sub-module, reset_hold_counter, instantiated twice (system and video). Its ports:
  - CLK, RESET_n, EN (count strobe), QUAL (count qualifier; low clears the count), DONE_n (registered output).

Test Plan:
- RESET_n low for 8 cycles, then high. Check:
  - All outputs are 0 during reset.
  - EN_21M first asserts at cycle 5; EN_3M58_R at cycle 30; EN_3M58_F at cycle 15.
  - Over 300 cycles: exactly 60 EN_21M, 30 EN_10M and 10 EN_3M58_R.
  - CLK_3M58 has a 15/15 duty.
- Reset sequencing with TMDS_READY=1 held from the start:
  - SYS_RESET_n rises on the cycle after the 16th EN_3M58_R (cycle 481).
  - VID_RESET_n rises 16 EN_3M58_R pulses later.
- After VID_RESET_n=1, drop TMDS_READY for 3 cycles:
  - VID_RESET_n falls within SYNC_STAGES+1 cycles.
  - It rises again 16 CPU periods after the synchronized TMDS_READY returns.
  - SYS_RESET_n stays 1 throughout.
- Assert PAUSE_REQ at pcnt=3:
  - The EN_3M58_R at pcnt=29 still fires, then PAUSE_ACK=1 and no EN_* pulses for 100 cycles.
  - Release PAUSE_REQ: PAUSE_ACK drops and the next EN_3M58_R comes 30 cycles later.
- Assert PAUSE_REQ at pcnt=5 and drop it at pcnt=20: PAUSE_ACK never asserts and the enable cadence is unchanged.
- Over 214800 cycles (including a pause): exactly 2 TICK_1K pulses, 107400 cycles apart.
- Pull RESET_n low while in PAUSED: all outputs are 0 on the next edge.

Source files
------------

// File: rtl/board_clock_enable_gen_pkg.sv
// Shared types and constants for the board clock-enable generator.
// Holds the pause FSM encoding, the fixed divisors and the pulse-offset helpers.
package board_clock_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } pause_state_e;

    localparam int BASE_FREQ_KHZ = 107400;
    localparam int DIV_21M       = 5;
    localparam int DIV_10M       = 10;

    // Prescaler values whose registered decode places the CPU rise/fall pulse.
    function automatic int rise_offset(input int base_div);
        return base_div - 1;
    endfunction

    function automatic int fall_offset(input int base_div);
        return (base_div / 2) - 1;
    endfunction

endpackage

// File: rtl/board_clock_enable_gen_reset_hold.sv
// Saturating hold counter that releases an active-low reset after HOLD strobes.
// QUAL low clears both the count and the released output.
module reset_hold_counter #(
    parameter int HOLD = 16
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic EN,
    input  logic QUAL,
    output logic DONE_n
);

    localparam int CW = $clog2(HOLD + 1);

    logic [CW-1:0] r_count;
    logic          r_done_n;

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            r_count  <= '0;
            r_done_n <= 1'b0;
        end else if (!QUAL) begin
            r_count  <= '0;
            r_done_n <= 1'b0;
        end else begin
            if (EN && (r_count != CW'(HOLD))) begin
                r_count <= r_count + 1'b1;
            end
            r_done_n <= (r_count == CW'(HOLD));
        end
    end

    assign DONE_n = r_done_n;

endmodule

// File: rtl/board_clock_enable_gen.sv
// Divides the 107.4 MHz base clock into phase-aligned enables, a 1 kHz tick,
// sequenced system/video resets and a CPU-boundary pause handshake.
module board_clock_enable_gen
    import board_clock_pkg::*;
#(
    parameter int BASE_DIV    = 30,
    parameter int TICK_DIV    = BASE_FREQ_KHZ,
    parameter int RST_HOLD    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic TMDS_READY,
    input  logic PAUSE_REQ,
    output logic PAUSE_ACK,
    output logic EN_21M,
    output logic EN_10M,
    output logic EN_3M58_R,
    output logic EN_3M58_F,
    output logic CLK_3M58,
    output logic TICK_1K,
    output logic SYS_RESET_n,
    output logic VID_RESET_n
);

    localparam int PW       = $clog2(BASE_DIV);
    localparam int RISE_OFS = rise_offset(BASE_DIV);
    localparam int FALL_OFS = fall_offset(BASE_DIV);

    pause_state_e           r_state;
    logic                   r_ack;
    logic [PW-1:0]          r_pcnt;
    logic [3:0]             r_c10;
    logic [16:0]            r_tcnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_en_21m;
    logic                   r_en_10m;
    logic                   r_en_r;
    logic                   r_en_f;
    logic                   r_clk;
    logic                   r_tick;

    logic w_frozen;
    logic w_dec_21m;
    logic w_dec_10m;
    logic w_dec_r;
    logic w_dec_f;
    logic w_tmds_ok;
    logic w_sys_done_n;
    logic w_vid_done_n;

    // r_c10 runs in lockstep with r_pcnt (BASE_DIV is a multiple of 10),
    // so the fast enables decode from a 4-bit counter instead of a modulo.
    assign w_frozen  = (r_state == PAUSED);
    assign w_dec_r   = !w_frozen && (r_pcnt == PW'(RISE_OFS));
    assign w_dec_f   = !w_frozen && (r_pcnt == PW'(FALL_OFS));
    assign w_dec_10m = !w_frozen && (r_c10 == 4'(DIV_10M - 1));
    assign w_dec_21m = !w_frozen && ((r_c10 == 4'(DIV_21M - 1)) || (r_c10 == 4'(DIV_10M - 1)));
    assign w_tmds_ok = r_sync[SYNC_STAGES-1];

    // Pause handshake: the requester holds PAUSE_REQ high until PAUSE_ACK is
    // seen. ACK rises with the CPU rise pulse that ends the drain and falls on
    // the edge REQ is seen low; dropping REQ before ACK cancels the request.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            r_state <= RUN;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (PAUSE_REQ) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!PAUSE_REQ) begin
                        r_state <= RUN;
                    end else if (w_dec_r) begin
                        r_state <= PAUSED;
                        r_ack   <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (!PAUSE_REQ) begin
                        r_state <= RUN;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            r_pcnt <= '0;
            r_c10  <= '0;
        end else if (!w_frozen) begin
            r_pcnt <= (r_pcnt == PW'(BASE_DIV - 1)) ? '0 : r_pcnt + 1'b1;
            r_c10  <= (r_c10 == 4'(DIV_10M - 1)) ? '0 : r_c10 + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            r_en_21m <= 1'b0;
            r_en_10m <= 1'b0;
            r_en_r   <= 1'b0;
            r_en_f   <= 1'b0;
            r_clk    <= 1'b0;
        end else begin
            r_en_21m <= w_dec_21m;
            r_en_10m <= w_dec_10m;
            r_en_r   <= w_dec_r;
            r_en_f   <= w_dec_f;
            if (w_dec_r) begin
                r_clk <= 1'b1;
            end else if (w_dec_f) begin
                r_clk <= 1'b0;
            end
        end
    end

    // The millisecond tick keeps running through a pause.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            r_tcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tcnt <= (r_tcnt == 17'(TICK_DIV - 1)) ? '0 : r_tcnt + 1'b1;
            r_tick <= (r_tcnt == 17'(TICK_DIV - 1));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], TMDS_READY};
        end
    end

    reset_hold_counter #(.HOLD(RST_HOLD)) u_sys_hold (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .EN      (w_dec_r),
        .QUAL    (1'b1),
        .DONE_n  (w_sys_done_n)
    );

    reset_hold_counter #(.HOLD(RST_HOLD)) u_vid_hold (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .EN      (w_dec_r),
        .QUAL    (w_tmds_ok & w_sys_done_n),
        .DONE_n  (w_vid_done_n)
    );

    assign PAUSE_ACK   = r_ack;
    assign EN_21M      = r_en_21m;
    assign EN_10M      = r_en_10m;
    assign EN_3M58_R   = r_en_r;
    assign EN_3M58_F   = r_en_f;
    assign CLK_3M58    = r_clk;
    assign TICK_1K     = r_tick;
    assign SYS_RESET_n = w_sys_done_n;
    assign VID_RESET_n = w_vid_done_n;

endmodule
